// File: rtl/mudi_ctrl.sv
// Multiply/divide sequencer: accepts one mult/multu/div/divu/mthi/mtlo per issue,
// holds Busy for the fixed operation latency, then commits the pending result to HI/LO.
module mudi_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic        Cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic        pend_wr_r;

    logic        accept_s;
    logic        is_div_s;
    logic [3:0]  load_cnt_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [31:0] dvd_s;
    logic [31:0] dvs_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Result datapath: one shared multiplier and one unsigned divider on magnitudes
    always_comb begin
        accept_s   = Start & ~Cancel & ~busy_r & (Op != 3'd0) & (Op != 3'd7);
        is_div_s   = (Op == OP_DIV) || (Op == OP_DIVU);
        load_cnt_s = is_div_s ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        mul_a_s    = (Op == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
        mul_b_s    = (Op == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
        prod_s     = mul_a_s * mul_b_s;
        // Signed divide works on magnitudes; 0x80000000 stays 2^31 as an unsigned magnitude
        dvd_s      = ((Op == OP_DIV) && A[31]) ? (32'd0 - A) : A;
        dvs_s      = ((Op == OP_DIV) && B[31]) ? (32'd0 - B) : B;
        uq_s       = (dvs_s == 32'd0) ? 32'd0 : (dvd_s / dvs_s);
        ur_s       = (dvs_s == 32'd0) ? 32'd0 : (dvd_s % dvs_s);
        res_hi_s   = 32'd0;
        res_lo_s   = 32'd0;
        case (Op)
            OP_MULT, OP_MULTU: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            OP_DIV: begin
                res_lo_s = (A[31] ^ B[31]) ? (32'd0 - uq_s) : uq_s;
                res_hi_s = A[31] ? (32'd0 - ur_s) : ur_s;
            end
            OP_DIVU: begin
                res_lo_s = uq_s;
                res_hi_s = ur_s;
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
            end
        endcase
    end

    // Sequencer FSM: accept, count down the latency, commit on the last busy cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (Op)
                            OP_MTHI: hi_r <= A;
                            OP_MTLO: lo_r <= A;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_hi_r <= res_hi_s;
                                pend_lo_r <= res_lo_s;
                                pend_wr_r <= ~(is_div_s && (B == 32'd0));
                                cnt_r     <= load_cnt_s;
                                busy_r    <= 1'b1;
                                state_r   <= ST_RUN;
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt_r == 4'd1) begin
                        if (pend_wr_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                        pend_wr_r <= 1'b0;
                        cnt_r     <= 4'd0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: doc/mudi_ctrl.md
Name: mudi_ctrl

Overview:
- Sequencer for the multiply/divide resource: accepts one mult/multu/div/divu/mthi/mtlo per issue, models the fixed multi-cycle latency, and commits results to architectural HI/LO.
- Sits in the E stage beside the ALU. Its Busy output drives the hazard unit's MuDiBusy input, which stalls mf/mt/mudi instructions in D while an operation is in flight.
- Supports same-cycle cancellation, so an exception/interrupt flush of the issuing instruction never modifies HI/LO.

Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (1..15)
- DIV_CYCLES, 10, Busy duration for div/divu (1..15)

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high
- Start  input  1  issue strobe from E stage, one cycle per instruction
- Op  input  3  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 are no-op
- Cancel  input  1  flush of the issuing instruction; qualifies Start in the same cycle only
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Busy  output  1  operation in flight (registered)
- HI  output  32  architectural HI (registered)
- LO  output  32  architectural LO (registered)

Behaviour:
- Reset: synchronous, active-high, clock Clk. Busy=0, HI=0, LO=0, counter=0, pending result cleared. Reset mid-operation aborts it; no commit follows.
- Accept condition: Start & ~Cancel & ~Busy & Op in 1..6. Every other Start is ignored with no state change. Start while Busy cannot legally occur because the hazard unit stalls; it is still ignored.
- mthi/mtlo: accepted at edge T, HI (or LO) = A visible in cycle T+1. Busy stays 0. The other register is unchanged.
- mult/multu/div/divu accepted at edge T:
  - result is computed from A and B at T and latched into pending PHI/PLO;
  - 4-bit counter loads N (MULT_CYCLES or DIV_CYCLES);
  - Busy = (counter != 0), high for cycles T+1..T+N;
  - at the edge where counter==1, HI=PHI and LO=PLO are written and counter goes to 0;
  - new HI/LO and Busy=0 are both visible in cycle T+N+1. HI/LO keep their old values during Busy.
- A/B may change after T without effect.
- States: IDLE (counter==0), RUN (counter!=0). IDLE->RUN on accept of mult/div; RUN->IDLE on commit; RUN->IDLE on Reset.
- Arithmetic:
  - mult: signed 32x32->64, {HI,LO} = product.
  - multu: unsigned 32x32->64.
  - div: signed, quotient truncates toward zero into LO; remainder into HI, with the sign of the dividend.
  - divu: unsigned.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0, div or divu): operation runs the full DIV_CYCLES with Busy, but commit leaves HI and LO unchanged.
- Commit and new Start on the same edge is impossible, since Busy is still 1 in the commit cycle; a Start in that cycle is ignored.
- Cancel has no effect on an operation already in RUN; only the same-cycle Start is suppressed.
- Op 0/7 with Start: no-op, Busy stays 0.

Test Plan:
- Reset, then Start Op=1 A=0xFFFFFFFE B=3 -> Busy high exactly 5 cycles; next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- Op=2 A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001; HI/LO hold prior values during Busy.
- Op=3 A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; also Op=3 A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Op=4 A=100 B=0 after HI=0x11, LO=0x22 -> Busy 10 cycles, HI/LO remain 0x11/0x22; Start Op=5 A=0x1234 with Cancel=1 -> HI unchanged; without Cancel, HI=0x1234 next cycle, Busy never asserted.
- Op=1 accepted, Reset asserted in the 3rd Busy cycle -> next cycle Busy=0, HI=LO=0, and no later commit occurs.
- Start Op=6 A=5 while Busy from a mult -> ignored: LO after commit equals the mult result, not 5; Start with Op=0 -> no state change.
